// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU.
// Holds the opcode encoding, the control FSM state encoding and a small
// opcode classification helper used by the top level.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_MUL    = 4'h2,
        OP_DIV    = 4'h3,
        OP_AND    = 4'h4,
        OP_OR     = 4'h5,
        OP_XOR    = 4'h6,
        OP_NOT    = 4'h7,
        OP_LNOT   = 4'h8,
        OP_SHL    = 4'h9,
        OP_SHR    = 4'hA,
        OP_PASS_A = 4'hB,
        OP_PASS_B = 4'hC,
        OP_REM    = 4'hD,
        OP_ILL_E  = 4'hE,
        OP_ILL_F  = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DIV_FIX = 2'd2
    } state_e;

    // True for the two opcodes that use the iterative divider.
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_mc_divider.sv
// Iterative restoring divider on unsigned magnitudes.
// One quotient bit per cycle, WIDTH cycles per divide.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             load operands and begin a divide
//   dividend_i          dividend magnitude
//   divisor_i           divisor magnitude (must be non-zero)
//   busy_o              a divide is in progress
//   done_o              the final step happens on the coming edge
//   quotient_o          quotient (valid the cycle after done_o)
//   remainder_o         remainder (valid the cycle after done_o)
module alu_mc_divider #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] rem_nx_s;
    logic [WIDTH-1:0] quo_nx_s;

    // One restoring step: shift the next dividend bit in, try to subtract.
    always_comb begin
        rem_sh_s = {rem_r, quo_r[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, dvs_r};
        if (diff_s[WIDTH]) begin
            rem_nx_s = rem_sh_s[WIDTH-1:0];
            quo_nx_s = {quo_r[WIDTH-2:0], 1'b0};
        end else begin
            rem_nx_s = diff_s[WIDTH-1:0];
            quo_nx_s = {quo_r[WIDTH-2:0], 1'b1};
        end
    end

    // Operand load, iteration and step counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            quo_r  <= {WIDTH{1'b0}};
            rem_r  <= {WIDTH{1'b0}};
            dvs_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
        end else if (start_i) begin
            quo_r  <= dividend_i;
            rem_r  <= {WIDTH{1'b0}};
            dvs_r  <= divisor_i;
            cnt_r  <= CNT_W'(WIDTH - 1);
            busy_r <= 1'b1;
        end else if (busy_r) begin
            quo_r <= quo_nx_s;
            rem_r <= rem_nx_s;
            if (cnt_r == {CNT_W{1'b0}}) begin
                busy_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign busy_o      = busy_r;
    assign done_o      = busy_r && (cnt_r == {CNT_W{1'b0}});
    assign quotient_o  = quo_r;
    assign remainder_o = rem_r;

endmodule

// File: rtl/alu_mc_unit.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops register their result at the accept edge; DIV/REM with a
// non-zero divisor run the iterative divider and apply signs afterwards.
// Ports:
//   clk_i, rst_i                clock, synchronous active-high reset
//   in_valid_i / in_ready_o     operand handshake
//   op_i, signed_i              opcode, two's-complement mode
//   reg_a_i, reg_b_i            operands
//   out_valid_o / out_ready_i   result handshake
//   result_o, zero_o            result and result==0 flag
//   arith_error_o               div by zero, signed DIV overflow, illegal op
module alu_mc_unit
    import alu_mc_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       op_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] reg_a_i,
    input  logic [WIDTH-1:0] reg_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             arith_error_o
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_C  = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_r;
    state_e             state_nx_s;
    op_e                op_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               b_zero_s;
    logic               div_ovf_s;
    logic               div_start_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_err_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic               div_busy_s;
    logic               div_done_s;
    logic [WIDTH-1:0]   div_quo_s;
    logic [WIDTH-1:0]   div_rem_s;
    logic [WIDTH-1:0]   fix_res_s;
    logic               is_rem_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               ovf_r;
    logic [WIDTH-1:0]   result_r;
    logic               zero_r;
    logic               err_r;
    logic               out_valid_r;

    assign op_s        = op_e'(op_i);
    assign in_ready_s  = (state_r == IDLE) && (!out_valid_r || out_ready_i);
    assign accept_s    = in_valid_i && in_ready_s;
    assign b_zero_s    = (reg_b_i == ZERO_C);
    // MIN / -1 overflows the quotient; the divider still runs and naturally
    // yields MIN and 0, only the error flag needs raising.
    assign div_ovf_s   = signed_i && (reg_a_i == MIN_C) && (reg_b_i == ONES_C);
    assign div_start_s = accept_s && is_div_op(op_i) && !b_zero_s;
    assign shamt_s     = reg_b_i[SHAMT_W-1:0];
    assign mag_a_s     = (signed_i && reg_a_i[WIDTH-1]) ? (~reg_a_i + ONE_C) : reg_a_i;
    assign mag_b_s     = (signed_i && reg_b_i[WIDTH-1]) ? (~reg_b_i + ONE_C) : reg_b_i;

    // Single-cycle datapath, including the divide-by-zero shortcut.
    always_comb begin
        alu_res_s = ZERO_C;
        alu_err_s = 1'b0;
        case (op_s)
            OP_ADD:    alu_res_s = reg_a_i + reg_b_i;
            OP_SUB:    alu_res_s = reg_a_i - reg_b_i;
            OP_MUL:    alu_res_s = reg_a_i * reg_b_i;
            OP_DIV: begin
                alu_res_s = b_zero_s ? ONES_C : ZERO_C;
                alu_err_s = b_zero_s;
            end
            OP_AND:    alu_res_s = reg_a_i & reg_b_i;
            OP_OR:     alu_res_s = reg_a_i | reg_b_i;
            OP_XOR:    alu_res_s = reg_a_i ^ reg_b_i;
            OP_NOT:    alu_res_s = ~reg_a_i;
            OP_LNOT:   alu_res_s = {{(WIDTH-1){1'b0}}, (reg_a_i == ZERO_C)};
            OP_SHL:    alu_res_s = reg_a_i << shamt_s;
            OP_SHR:    alu_res_s = signed_i ? $unsigned($signed(reg_a_i) >>> shamt_s)
                                            : (reg_a_i >> shamt_s);
            OP_PASS_A: alu_res_s = reg_a_i;
            OP_PASS_B: alu_res_s = reg_b_i;
            OP_REM: begin
                alu_res_s = b_zero_s ? reg_a_i : ZERO_C;
                alu_err_s = b_zero_s;
            end
            default: begin
                alu_res_s = ZERO_C;
                alu_err_s = 1'b1;
            end
        endcase
    end

    alu_mc_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (div_start_s),
        .dividend_i  (mag_a_s),
        .divisor_i   (mag_b_s),
        .busy_o      (div_busy_s),
        .done_o      (div_done_s),
        .quotient_o  (div_quo_s),
        .remainder_o (div_rem_s)
    );

    // Sign fix-up: quotient negative iff signs differ, remainder follows A.
    always_comb begin
        if (is_rem_r) begin
            fix_res_s = neg_r_r ? (~div_rem_s + ONE_C) : div_rem_s;
        end else begin
            fix_res_s = neg_q_r ? (~div_quo_s + ONE_C) : div_quo_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; a divider that stops early drops back to IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = div_start_s ? DIV_RUN : IDLE;
            DIV_RUN: begin
                if (div_done_s) begin
                    state_nx_s = DIV_FIX;
                end else if (!div_busy_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DIV_RUN;
                end
            end
            DIV_FIX: state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Result register, flags, divide context and output valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_r    <= ZERO_C;
            zero_r      <= 1'b0;
            err_r       <= 1'b0;
            out_valid_r <= 1'b0;
            is_rem_r    <= 1'b0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (div_start_s) begin
            out_valid_r <= 1'b0;
            is_rem_r    <= (op_s == OP_REM);
            neg_q_r     <= signed_i && (reg_a_i[WIDTH-1] ^ reg_b_i[WIDTH-1]);
            neg_r_r     <= signed_i && reg_a_i[WIDTH-1];
            ovf_r       <= div_ovf_s;
        end else if (accept_s) begin
            result_r    <= alu_res_s;
            zero_r      <= (alu_res_s == ZERO_C);
            err_r       <= alu_err_s;
            out_valid_r <= 1'b1;
        end else if (state_r == DIV_FIX) begin
            result_r    <= fix_res_s;
            zero_r      <= (fix_res_s == ZERO_C);
            err_r       <= ovf_r;
            out_valid_r <= 1'b1;
        end else if (out_ready_i) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready_o    = in_ready_s;
    assign out_valid_o   = out_valid_r;
    assign result_o      = result_r;
    assign zero_o        = zero_r;
    assign arith_error_o = err_r;

endmodule

// File: tb/tb_alu_mc_unit.sv
// Self-checking bench for alu_mc_unit (WIDTH=16): directed vector table,
// hand-written handshake/reset sequences and randomized ops against a
// behavioural model built from plain integer arithmetic.
module tb_alu_mc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        zero;
    logic        err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    alu_mc_unit #(.WIDTH(16)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .op_i          (op),
        .signed_i      (sgn),
        .reg_a_i       (a),
        .reg_b_i       (b),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .result_o      (result),
        .zero_o        (zero),
        .arith_error_o (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [3:0] o, input logic s,
                           input logic [15:0] va, input logic [15:0] vb,
                           input logic [15:0] r, input logic e, input int l);
        vec_t v;
        v.name = name; v.op = o; v.sgn = s; v.a = va; v.b = vb;
        v.res = r; v.err = e; v.lat = l;
        vecs.push_back(v);
    endtask

    // Reference model: integer arithmetic on the operand values.
    function automatic void model(input logic [3:0] o, input logic s,
                                  input logic [15:0] va, input logic [15:0] vb,
                                  output logic [15:0] r, output logic e, output int l);
        longint ua, ub, sa, sb, x;
        logic [3:0] sh;
        ua = longint'(va);
        ub = longint'(vb);
        sa = s ? longint'($signed(va)) : ua;
        sb = s ? longint'($signed(vb)) : ub;
        sh = vb[3:0];
        x = 0; e = 1'b0; l = 1;
        case (o)
            4'h0: x = ua + ub;
            4'h1: x = ua - ub;
            4'h2: x = ua * ub;
            4'h3: begin
                if (vb == 16'h0000) begin x = 65535; e = 1'b1; end
                else begin
                    l = 18;
                    if (s && va == 16'h8000 && vb == 16'hFFFF) begin x = 32768; e = 1'b1; end
                    else x = sa / sb;
                end
            end
            4'h4: x = ua & ub;
            4'h5: x = ua | ub;
            4'h6: x = ua ^ ub;
            4'h7: x = ~ua;
            4'h8: x = (va == 16'h0000) ? 1 : 0;
            4'h9: x = ua << sh;
            4'hA: x = s ? (sa >>> sh) : (ua >> sh);
            4'hB: x = ua;
            4'hC: x = ub;
            4'hD: begin
                if (vb == 16'h0000) begin x = ua; e = 1'b1; end
                else begin
                    l = 18;
                    if (s && va == 16'h8000 && vb == 16'hFFFF) begin x = 0; e = 1'b1; end
                    else x = sa % sb;
                end
            end
            default: begin x = 0; e = 1'b1; end
        endcase
        r = x[15:0];
    endfunction

    // Issue one op with out_ready=1 and check result, flags and latency.
    task automatic run_op(input string name, input logic [3:0] o, input logic s,
                          input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] er, input logic ee, input int el);
        int guard;
        int lat;
        logic rdy_low;
        @(negedge clk);
        op = o; sgn = s; a = va; b = vb; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk({name, " accept"}, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        rdy_low = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_low = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({name, " valid"}, 32'(out_valid), 32'd1);
        chk({name, " result"}, 32'(result), 32'(er));
        chk({name, " error"}, 32'(err), 32'(ee));
        chk({name, " zero"}, 32'(zero), 32'(er == 16'h0000));
        chk({name, " latency"}, 32'(lat), 32'(el));
        if (el > 1) chk({name, " in_ready low"}, 32'(rdy_low), 32'd1);
    endtask

    initial begin
        logic [15:0] mr;
        logic        me;
        int          ml;
        logic [3:0]  ro;
        logic        rs;
        logic [15:0] ra, rb;
        logic        seen;

        rst = 1'b1; in_valid = 1'b0; op = 4'h0; sgn = 1'b0;
        a = 16'h0000; b = 16'h0000; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset zero", 32'(zero), 32'd0);
        chk("reset error", 32'(err), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        // Back-to-back ADD then SUB at 1 op/cycle.
        op = 4'h0; sgn = 1'b0; a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1;
        chk("b2b ready1", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b add valid", 32'(out_valid), 32'd1);
        chk("b2b add result", 32'(result), 32'h0000);
        chk("b2b add zero", 32'(zero), 32'd1);
        chk("b2b add error", 32'(err), 32'd0);
        chk("b2b ready2", 32'(in_ready), 32'd1);
        op = 4'h1; a = 16'h0000; b = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b sub valid", 32'(out_valid), 32'd1);
        chk("b2b sub result", 32'(result), 32'hFFFF);
        chk("b2b sub zero", 32'(zero), 32'd0);
        chk("b2b sub error", 32'(err), 32'd0);

        // Directed vectors.
        add_vec("div u 100/7",     4'h3, 1'b0, 16'd100,  16'd7,    16'd14,   1'b0, 18);
        add_vec("rem u 100/7",     4'hD, 1'b0, 16'd100,  16'd7,    16'd2,    1'b0, 18);
        add_vec("div s -7/2",      4'h3, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0, 18);
        add_vec("rem s -7/2",      4'hD, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 1'b0, 18);
        add_vec("div s 7/-2",      4'h3, 1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 1'b0, 18);
        add_vec("rem s 7/-2",      4'hD, 1'b1, 16'h0007, 16'hFFFE, 16'h0001, 1'b0, 18);
        add_vec("div s min/-1",    4'h3, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 18);
        add_vec("div u ffff/1",    4'h3, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 18);
        add_vec("div 5/0",         4'h3, 1'b0, 16'h0005, 16'h0000, 16'hFFFF, 1'b1, 1);
        add_vec("rem 5/0",         4'hD, 1'b0, 16'h0005, 16'h0000, 16'h0005, 1'b1, 1);
        add_vec("illegal F",       4'hF, 1'b0, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1);
        add_vec("illegal E",       4'hE, 1'b1, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1);
        add_vec("shr s 8000>>4",   4'hA, 1'b1, 16'h8000, 16'h0004, 16'hF800, 1'b0, 1);
        add_vec("shr u 8000>>4",   4'hA, 1'b0, 16'h8000, 16'h0004, 16'h0800, 1'b0, 1);
        add_vec("shl 1<<0x13",     4'h9, 1'b0, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1);
        add_vec("mul wrap",        4'h2, 1'b0, 16'h1234, 16'h0100, 16'h3400, 1'b0, 1);
        add_vec("lnot 0",          4'h8, 1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1);
        add_vec("lnot 5",          4'h8, 1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1);
        add_vec("not a",           4'h7, 1'b0, 16'h0F0F, 16'h0000, 16'hF0F0, 1'b0, 1);
        add_vec("pass b",          4'hC, 1'b0, 16'h1111, 16'hBEEF, 16'hBEEF, 1'b0, 1);
        add_vec("xor",             4'h6, 1'b0, 16'hFF00, 16'h0FF0, 16'hF0F0, 1'b0, 1);
        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].err, vecs[i].lat);
        end

        // Backpressure: result holds, new op held by producer until released.
        @(negedge clk);
        out_ready = 1'b0;
        op = 4'h4; sgn = 1'b0; a = 16'hF0F0; b = 16'h0FF0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op = 4'h0; a = 16'h0001; b = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            chk("bp valid", 32'(out_valid), 32'd1);
            chk("bp result", 32'(result), 32'h00F0);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp next valid", 32'(out_valid), 32'd1);
        chk("bp next result", 32'(result), 32'h0002);

        // Reset in the middle of a divide discards it.
        @(negedge clk);
        op = 4'h3; sgn = 1'b0; a = 16'd100; b = 16'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid-div busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid-div reset valid", 32'(out_valid), 32'd0);
        chk("mid-div reset ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mid-div never completes", 32'(seen), 32'd0);

        // Randomized ops against the model.
        for (int i = 0; i < 150; i++) begin
            ro = 4'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 16'h0000;
                1:       rb = 16'($urandom_range(1, 20));
                2:       rb = 16'hFFFF - 16'($urandom_range(0, 5));
                default: rb = 16'($urandom);
            endcase
            model(ro, rs, ra, rb, mr, me, ml);
            run_op($sformatf("rand%0d op%0h", i, ro), ro, rs, ra, rb, mr, me, ml);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_mc_unit.md
Name: alu_mc_unit

Overview:
Parametrised multi-cycle successor to the single-cycle 16-bit ALU in the execute stage.
- Adds a generic WIDTH, a signed/unsigned mode, real shifts, and an iterative restoring divider with quotient and remainder.
- Adds divide-by-zero/overflow error reporting and valid/ready handshakes on both operand and result sides, so the issue logic can stall on long divides.

Parameters:
WIDTH, 16, operand/result width in bits (>= 4)
SHAMT_W, $clog2(WIDTH), shift-amount bits taken from reg_b_i LSBs

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
in_valid_i  in  1  operands/op presented
in_ready_o  out  1  unit accepts a new op this cycle
op_i  in  4  opcode
signed_i  in  1  1 = two's-complement operands (DIV/REM/SHR/flags)
reg_a_i  in  WIDTH  operand A
reg_b_i  in  WIDTH  operand B
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer takes result
result_o  out  WIDTH  result
zero_o  out  1  result_o == 0
arith_error_o  out  1  error for this result (div by zero, signed overflow of DIV, illegal op)

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL (low WIDTH bits), 3 DIV (quotient), 4 AND, 5 OR, 6 XOR, 7 NOT A (bitwise).
  - 8 LNOT (result = {0..,A==0}), 9 SHL, A SHR (arithmetic if signed_i, else logical), B PASS A, C PASS B, D REM.
  - E/F illegal: result 0, arith_error_o=1.
- Handshake: transfer when valid&&ready on the same edge. in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i). The result register holds stable while out_valid_o && !out_ready_i.
- Latency: non-divide ops register the result at the accept edge, so out_valid_o rises the next cycle. Back-to-back single-cycle ops sustain 1 op/cycle when out_ready_i=1.
- FSM states:
  - IDLE: accept. DIV/REM with B!=0 -> DIV_RUN; everything else stays in IDLE.
  - DIV_RUN: one restoring-division step per cycle on magnitudes, WIDTH cycles, counter WIDTH-1 down to 0. At 0 -> DIV_FIX.
  - DIV_FIX: apply signs (quotient negative iff signs differ; remainder takes sign of A), load result, out_valid_o=1 -> IDLE.
  - DIV/REM total latency: WIDTH+2 cycles from accept to out_valid_o.
- Divide by zero: no iteration. Completes like a single-cycle op. DIV result all-ones, REM result = A, arith_error_o=1.
- Signed DIV of MIN by -1: result MIN, REM 0, arith_error_o=1, full iteration latency.
- Shifts use reg_b_i[SHAMT_W-1:0]; upper B bits are ignored.
- ADD/SUB/MUL wrap modulo 2^WIDTH, with no error.
- zero_o and arith_error_o are registered with result_o and valid only while out_valid_o=1.
- in_valid_i while in_ready_o=0: ignored; the producer must hold.
- Reset (any state, including mid-divide): state IDLE, counter 0, out_valid_o=0, result_o=0, zero_o=0, arith_error_o=0. in_ready_o=1 the cycle after reset deasserts. Any in-flight divide is discarded.

Decomposition:
- Package alu_mc_pkg holds:
  - the opcode enum/localparams (OP_ADD..OP_REM, OP_ILLEGAL range);
  - the FSM state encoding (IDLE, DIV_RUN, DIV_FIX).
- One sub-module, alu_mc_divider, holds the iterative magnitude divider: start/busy/done, quotient, remainder.
- The top module holds the handshake, the single-cycle datapath and the sign fix-up.

Test Plan:
- WIDTH=16, out_ready_i=1: ADD 0xFFFF+0x0001 then SUB 0x0000-0x0001 back-to-back -> results 0x0000 (zero_o=1) and 0xFFFF on consecutive cycles, no error.
- DIV unsigned 100/7 -> out_valid_o exactly 18 cycles after accept, result 14. REM 100/7 -> 2. in_ready_o=0 throughout.
- Signed DIV -7/2 -> 0xFFFD (-3). Signed REM -7/2 -> 0xFFFF (-1). Signed DIV 0x8000/0xFFFF -> 0x8000, arith_error_o=1.
- DIV 5/0 -> next-cycle result 0xFFFF, arith_error_o=1. REM 5/0 -> 0x0005, arith_error_o=1. Opcode 0xF -> 0x0000, error.
- SHR 0x8000 by 4: signed_i=1 -> 0xF800, signed_i=0 -> 0x0800. SHL 0x0001 by 0x0013 -> 0x0008 (amount masked to 3).
- Backpressure: out_ready_i=0 for 5 cycles after AND 0xF0F0&0x0FF0 -> result holds 0x00F0 and in_ready_o=0. Reset asserted mid-DIV -> out_valid_o=0 next cycle and the divide never completes.
